// File: rtl/mult_pkg.sv
// Shared widths and helpers for the sign-magnitude 5x5 -> 9 bit multiplier.
// Operands are split into sign + 4-bit magnitude; the product is re-signed.
package mult_pkg;

  localparam int OPW   = 5;
  localparam int MAGW  = 4;
  localparam int PRODW = 9;

  typedef struct packed {
    logic            sign;
    logic [MAGW-1:0] mag;
  } opnd_t;

  // -16 has no 4-bit magnitude, so it saturates to 15 and keeps its sign.
  function automatic opnd_t sat_mag(input logic [OPW-1:0] x);
    opnd_t           r;
    logic [OPW-1:0]  neg;
    neg    = ~x + 1'b1;
    r.sign = x[OPW-1];
    if (!x[OPW-1])
      r.mag = x[MAGW-1:0];
    else if (neg[OPW-1])
      r.mag = {MAGW{1'b1}};
    else
      r.mag = neg[MAGW-1:0];
    return r;
  endfunction

  function automatic logic [PRODW-1:0] neg9(input logic [PRODW-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/mult_4x4_unsigned_array.sv
// Combinational 4x4 unsigned array multiplier: AND-gate partial products
// accumulated row by row with half/full adder ripple rows.
module mult_4x4_unsigned_array
  import mult_pkg::*;
(
  input  logic [MAGW-1:0]   a,
  input  logic [MAGW-1:0]   b,
  output logic [2*MAGW-1:0] p
);

  logic [MAGW-1:0][MAGW-1:0] pp;    // pp[row][col] = a[col] & b[row]
  logic [MAGW-1:0][MAGW-1:0] s;     // row sums
  logic [MAGW-1:0]           co;    // row carry-outs
  logic [MAGW-1:0][MAGW:0]   cy;    // ripple carries inside each row

  genvar i, j;
  generate
    for (i = 0; i < MAGW; i++) begin : g_pp
      for (j = 0; j < MAGW; j++) begin : g_col
        assign pp[i][j] = a[j] & b[i];
      end
    end
  endgenerate

  // Row 0 is the bare first partial product.
  assign s[0]     = pp[0];
  assign co[0]    = 1'b0;
  assign cy[0]    = '0;

  // Each row adds the next partial product to the previous row shifted right
  // by one; the dropped LSB is a finished product bit.
  generate
    for (i = 1; i < MAGW; i++) begin : g_row
      logic [MAGW-1:0] x;
      assign x        = {co[i-1], s[i-1][MAGW-1:1]};
      assign cy[i][0] = 1'b0;
      for (j = 0; j < MAGW; j++) begin : g_bit
        if (j == 0) begin : g_ha
          assign s[i][j]    = x[j] ^ pp[i][j];
          assign cy[i][j+1] = x[j] & pp[i][j];
        end else begin : g_fa
          assign s[i][j]    = x[j] ^ pp[i][j] ^ cy[i][j];
          assign cy[i][j+1] = (x[j] & pp[i][j]) | (cy[i][j] & (x[j] ^ pp[i][j]));
        end
      end
      assign co[i] = cy[i][MAGW];
    end
  endgenerate

  generate
    for (i = 0; i < MAGW; i++) begin : g_lo
      assign p[i] = s[i][0];
    end
  endgenerate

  assign p[2*MAGW-1:MAGW] = {co[MAGW-1], s[MAGW-1][MAGW-1:1]};

endmodule

// File: rtl/multiplier_4_bit_unsigned.sv
// Registered sign-magnitude multiplier: 5-bit signed operands, 9-bit signed
// product, one cycle latency, one product per clock.
module multiplier_4_bit_unsigned
  import mult_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [OPW-1:0]   i_as,
  input  logic [OPW-1:0]   i_bs,
  output logic [PRODW-1:0] o_fs
);

  opnd_t             op_a, op_b;
  logic [2*MAGW-1:0] mag_p;
  logic [PRODW-1:0]  mag_ext;
  logic              neg;
  logic [PRODW-1:0]  prod;

  assign op_a = sat_mag(i_as);
  assign op_b = sat_mag(i_bs);

  mult_4x4_unsigned_array u_array (
    .a (op_a.mag),
    .b (op_b.mag),
    .p (mag_p)
  );

  assign mag_ext = {1'b0, mag_p};
  // A zero magnitude stays positive so no negative-zero is ever produced.
  assign neg     = (op_a.sign ^ op_b.sign) && (mag_p != '0);
  assign prod    = neg ? neg9(mag_ext) : mag_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_fs <= '0;
    else          o_fs <= prod;
  end

endmodule

// File: tb/tb_multiplier_4_bit_unsigned.sv
// Self-checking bench: directed cases, reset behaviour, exhaustive sweep and
// random back-to-back traffic against a plain signed-arithmetic model.
module tb_multiplier_4_bit_unsigned;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [4:0] i_as, i_bs;
  logic [8:0] o_fs;

  int n_pass = 0;
  int n_total = 0;

  multiplier_4_bit_unsigned dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_as    (i_as),
    .i_bs    (i_bs),
    .o_fs    (o_fs)
  );

  always #5 i_clk = ~i_clk;

  // Reference: clamp -16 to -15, then ordinary signed multiply.
  function automatic logic [8:0] ref_mul(input logic [4:0] a, input logic [4:0] b);
    int x, y, p;
    x = int'($signed(a));
    y = int'($signed(b));
    if (x == -16) x = -15;
    if (y == -16) y = -15;
    p = x * y;
    return p[8:0];
  endfunction

  // Present operands, then sample just after the capturing edge.
  task automatic step(input logic [4:0] a, input logic [4:0] b);
    i_as = a;
    i_bs = b;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_as = 5'd5;
    i_bs = 5'd5;
    repeat (2) @(posedge i_clk);
    #1;
    n_total++;
    if (o_fs !== 9'h000) $display("FAIL reset_hold got=%h exp=%h", o_fs, 9'h000);
    else n_pass++;
    i_rst_n = 1'b1;
    step(5'd5, 5'd5);
    n_total++;
    if (o_fs !== 9'd25) $display("FAIL first_after_reset got=%h exp=%h", o_fs, 9'd25);
    else n_pass++;
    #2 i_rst_n = 1'b0;
    #1;
    n_total++;
    if (o_fs !== 9'h000) $display("FAIL async_reset got=%h exp=%h", o_fs, 9'h000);
    else n_pass++;
    i_as = 5'd7;
    i_bs = 5'd3;
    @(posedge i_clk);
    #1;
    n_total++;
    if (o_fs !== 9'h000) $display("FAIL reset_over_edge got=%h exp=%h", o_fs, 9'h000);
    else n_pass++;
    #2 i_rst_n = 1'b1;
    step(5'd5, 5'd5);
    n_total++;
    if (o_fs !== 9'd25) $display("FAIL release_reset got=%h exp=%h", o_fs, 9'd25);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [4:0] a_tab [9] = '{5'd0,  5'b10001, 5'b10001, 5'd1, 5'd7,     5'b10001, 5'b10000, 5'b10000, 5'd0};
    logic [4:0] b_tab [9] = '{5'd0,  5'd15,    5'd0,     5'd3, 5'b11000, 5'b10001, 5'd1,     5'b10000, 5'b10000};
    logic [8:0] e_tab [9] = '{9'h000, 9'h11F,  9'h000,   9'd3, 9'h1C8,   9'h0E1,   9'h1F1,   9'h0E1,   9'h000};
    logic [8:0] held;
    for (int k = 0; k < 9; k++) begin
      step(a_tab[k], b_tab[k]);
      n_total++;
      if (o_fs !== e_tab[k]) $display("FAIL directed_%0d a=%b b=%b got=%h exp=%h", k, a_tab[k], b_tab[k], o_fs, e_tab[k]);
      else n_pass++;
    end
    held = o_fs;
    i_as = 5'd9;
    i_bs = 5'd9;
    #3;
    n_total++;
    if (o_fs !== 9'h000) $display("FAIL hold_between_edges got=%h exp=%h", o_fs, 9'h000);
    else n_pass++;
    step(5'd9, 5'd9);
    n_total++;
    if (o_fs === held || o_fs !== 9'd81) $display("FAIL next_edge_update got=%h exp=%h", o_fs, 9'd81);
    else n_pass++;
  endtask

  task automatic test_exhaustive();
    int errs;
    logic [4:0] a, b;
    logic [8:0] e;
    errs = 0;
    for (int ia = 0; ia < 32; ia++) begin
      for (int ib = 0; ib < 32; ib++) begin
        a = ia[4:0];
        b = ib[4:0];
        e = ref_mul(a, b);
        step(a, b);
        n_total++;
        if (o_fs !== e) begin
          errs++;
          if (errs <= 10) $display("FAIL exhaustive a=%0d b=%0d got=%h exp=%h", $signed(a), $signed(b), o_fs, e);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] a, b;
    logic [8:0] e;
    for (int k = 0; k < 200; k++) begin
      a = 5'($urandom_range(31));
      b = 5'($urandom_range(31));
      e = ref_mul(a, b);
      step(a, b);
      n_total++;
      if (o_fs !== e) $display("FAIL random_%0d a=%b b=%b got=%h exp=%h", k, a, b, o_fs, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
